// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter sharing one register-file write port among
// N_REQ writeback sources; the accepted write reaches the RF one cycle later.
`default_nettype none

module rf_wb_arbiter #(
  parameter int ADDR  = 5,
  parameter int BUS_W = 32,
  parameter int N_REQ = 3,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*ADDR-1:0]  req_addr,
  input  logic [N_REQ*BUS_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   r_write,
  output logic [ADDR-1:0]        rd_addr,
  output logic [BUS_W-1:0]       rd_w_data,
  output logic [CNT_W-1:0]       wr_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] c_PTR_RST = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             write_q, write_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [BUS_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_gidx;
  logic             w_hs;
  logic [ADDR-1:0]  w_sel_addr;
  logic [BUS_W-1:0] w_sel_data;
  logic             w_commit;
  int               idx;

  // Search begins one past the last winner so every waiting source is served
  // within N_REQ grants.
  always_comb begin
    w_grant = '0;
    w_gidx  = ptr_q;
    w_hs    = 1'b0;
    idx     = 0;
    if (!freeze) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (int'(ptr_q) + k) % N_REQ;
        if (!w_hs && req_valid[idx]) begin
          w_hs         = 1'b1;
          w_grant[idx] = 1'b1;
          w_gidx       = IDX_W'(idx);
        end
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = w_sel_addr | req_addr[i*ADDR +: ADDR];
        w_sel_data = w_sel_data | req_data[i*BUS_W +: BUS_W];
      end
    end
  end

  assign w_commit = w_hs && (w_sel_addr != '0);

  always_comb begin
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    write_d = w_commit;
    if (w_hs) begin
      ptr_d  = w_gidx;
      addr_d = w_sel_addr;
      data_d = w_sel_data;
    end
    if (w_commit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= c_PTR_RST;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = w_grant;
  assign r_write   = write_q;
  assign rd_addr   = addr_q;
  assign rd_w_data = data_q;
  assign wr_cnt    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter (default build plus a CNT_W=4 build).
`default_nettype none

module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready, req_ready4;
  logic        r_write, r_write4;
  logic [4:0]  rd_addr, rd_addr4;
  logic [31:0] rd_w_data, rd_w_data4;
  logic [15:0] wr_cnt;
  logic [3:0]  wr_cnt4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.ADDR(5), .BUS_W(32), .N_REQ(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .r_write(r_write), .rd_addr(rd_addr), .rd_w_data(rd_w_data), .wr_cnt(wr_cnt)
  );

  rf_wb_arbiter #(.ADDR(5), .BUS_W(32), .N_REQ(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .freeze(freeze), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready4),
    .r_write(r_write4), .rd_addr(rd_addr4), .rd_w_data(rd_w_data4), .wr_cnt(wr_cnt4)
  );

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; freeze = 1'b0; req_valid = 3'b000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_srcs(input logic [4:0] a0, a1, a2, input logic [31:0] d0, d1, d2);
    req_addr = {a2, a1, a0};
    req_data = {d2, d1, d0};
  endtask

  task automatic test_reset();
    set_srcs(5'd1, 5'd2, 5'd3, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003);
    do_reset();
    req_valid = 3'b111;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({r_write, rd_addr, rd_w_data, wr_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got w=%0b a=%0d d=%h c=%0d, want all 0",
               r_write, rd_addr, rd_w_data, wr_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL reset_first_grant: got %b want 001", req_ready);
    end
    @(negedge clk);
    checks++;
    if (r_write !== 1'b1 || rd_addr !== 5'd1 || rd_w_data !== 32'h1111_0001) begin
      failures++;
      $display("FAIL reset_first_write: got w=%0b a=%0d d=%h want 1/1/11110001",
               r_write, rd_addr, rd_w_data);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [4:0] exp_a [6] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
    do_reset();
    set_srcs(5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (req_ready !== exp_g[c]) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, exp_g[c]);
      end
      @(negedge clk);
      checks++;
      if (r_write !== 1'b1 || rd_addr !== exp_a[c] || wr_cnt !== 16'(c + 1)) begin
        failures++;
        $display("FAIL rr_write[%0d]: got w=%0b a=%0d c=%0d want 1/%0d/%0d",
                 c, r_write, rd_addr, wr_cnt, exp_a[c], c + 1);
      end
    end
    req_valid = 3'b000;
    @(negedge clk);
    checks++;
    if (r_write !== 1'b0 || rd_addr !== 5'd3) begin
      failures++;
      $display("FAIL rr_idle: got w=%0b a=%0d want 0/3", r_write, rd_addr);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_srcs(5'd9, 5'd9, 5'd5, 32'h0, 32'h0, 32'hDEADBEEF);
    req_valid = 3'b100;
    #1;
    checks++;
    if (req_ready !== 3'b100 || wr_cnt !== 16'd0) begin
      failures++;
      $display("FAIL single_grant: got rdy=%b c=%0d want 100/0", req_ready, wr_cnt);
    end
    @(negedge clk);
    req_valid = 3'b000;
    checks++;
    if (r_write !== 1'b1 || rd_addr !== 5'd5 || rd_w_data !== 32'hDEADBEEF || wr_cnt !== 16'd1) begin
      failures++;
      $display("FAIL single_write: got w=%0b a=%0d d=%h c=%0d want 1/5/deadbeef/1",
               r_write, rd_addr, rd_w_data, wr_cnt);
    end
  endtask

  task automatic test_addr_zero();
    do_reset();
    set_srcs(5'd4, 5'd0, 5'd6, 32'h0, 32'hCAFE, 32'h0);
    req_valid = 3'b010;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      failures++;
      $display("FAIL zero_grant: got %b want 010", req_ready);
    end
    @(negedge clk);
    req_valid = 3'b000;
    checks++;
    if (r_write !== 1'b0 || wr_cnt !== 16'd0) begin
      failures++;
      $display("FAIL zero_write: got w=%0b c=%0d want 0/0", r_write, wr_cnt);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    set_srcs(5'd7, 5'd8, 5'd10, 32'h70, 32'h80, 32'hA0);
    req_valid = 3'b111;
    @(negedge clk);
    freeze = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 3'b000) begin
        failures++;
        $display("FAIL freeze_ready[%0d]: got %b want 000", c, req_ready);
      end
      @(negedge clk);
      checks++;
      if (r_write !== 1'b0 || rd_addr !== 5'd7 || wr_cnt !== 16'd1) begin
        failures++;
        $display("FAIL freeze_hold[%0d]: got w=%0b a=%0d c=%0d want 0/7/1",
                 c, r_write, rd_addr, wr_cnt);
      end
    end
    freeze = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      failures++;
      $display("FAIL freeze_resume: got %b want 010", req_ready);
    end
    @(negedge clk);
    req_valid = 3'b000;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_srcs(5'd11, 5'd12, 5'd13, 32'hB0, 32'hB1, 32'hB2);
    req_valid = 3'b101;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      failures++;
      $display("FAIL b2b_g0: got %b want 001", req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 3'b100 || rd_addr !== 5'd11) begin
      failures++;
      $display("FAIL b2b_g1: got rdy=%b a=%0d want 100/11", req_ready, rd_addr);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 3'b001 || rd_addr !== 5'd13 || rd_w_data !== 32'hB2) begin
      failures++;
      $display("FAIL b2b_g2: got rdy=%b a=%0d d=%h want 001/13/b2", req_ready, rd_addr, rd_w_data);
    end
    @(negedge clk);
    req_valid = 3'b000;
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    set_srcs(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    req_valid = 3'b001;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n == 15 || n == 16 || n == 17) begin
        checks++;
        if (wr_cnt4 !== 4'(n % 16)) begin
          failures++;
          $display("FAIL wrap_cnt4[%0d]: got %0d want %0d", n, wr_cnt4, n % 16);
        end
      end
    end
    req_valid = 3'b000;
    checks++;
    if (wr_cnt !== 16'd17) begin
      failures++;
      $display("FAIL wrap_cnt16: got %0d want 17", wr_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; req_valid = 3'b000;
    req_addr = '0; req_data = '0;
    #7;
    test_reset();
    test_round_robin();
    test_single();
    test_addr_zero();
    test_freeze();
    test_back_to_back();
    test_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
